// File: rtl/pipe_pkg.sv
// Shared pipeline types: hazard scoreboard record and bubble constants.
package pipe_pkg;

  // Widest register index the scoreboard record can carry; narrower
  // indices are zero-extended into it.
  localparam int REC_RD_W = 8;

  // Canonical bubble contents for a cleared pipeline register.
  localparam logic [31:0]         NOOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [REC_RD_W-1:0] ZERO_REG  = '0;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  // One in-flight producer. vld is set only for instructions that write rd.
  typedef struct packed {
    logic                vld;
    logic [REC_RD_W-1:0] rd;
    logic                is_load;
  } hazard_rec_t;

  localparam hazard_rec_t BUBBLE_REC = '{vld: 1'b0, rd: ZERO_REG, is_load: 1'b0};

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Count up on inc until all-ones, then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller: scoreboard of post-decode producers,
// RAW stall detection, branch flush, multi-cycle ALU hold, perf counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int PIPE_D   = 3,
  parameter int FWD      = 1,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_vld,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rd_wen,
  input  logic             id_is_load,
  input  logic             ex_take_br,
  input  logic             ex_busy,
  output logic             pc_hold,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_clr,
  output logic             id_ex_clr,
  output logic             ex_mem_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Slot 0 = EX, slot PIPE_D-1 = WB.
  hazard_rec_t r_sb [PIPE_D];

  logic [REC_RD_W-1:0] w_rs1_ext;
  logic [REC_RD_W-1:0] w_rs2_ext;
  logic                w_rs1_chk;
  logic                w_rs2_chk;
  logic [PIPE_D-1:0]   w_slot_haz;
  logic                w_raw_stall;
  hazard_rec_t         w_id_rec;
  logic                w_stall_inc;
  logic                w_flush_inc;

  assign w_rs1_ext = REC_RD_W'(id_rs1);
  assign w_rs2_ext = REC_RD_W'(id_rs2);
  // x0 never creates a dependency.
  assign w_rs1_chk = id_vld && id_rs1_used && (w_rs1_ext != ZERO_REG);
  assign w_rs2_chk = id_vld && id_rs2_used && (w_rs2_ext != ZERO_REG);

  // Per slot: a source matches the producer and its result is not yet
  // reachable. With forwarding only young loads are too late; without it
  // every producer before the write-through WB slot is too late.
  for (genvar k = 0; k < PIPE_D; k++) begin : g_slot
    logic w_match;
    assign w_match = r_sb[k].vld &&
                     ((w_rs1_chk && (r_sb[k].rd == w_rs1_ext)) ||
                      (w_rs2_chk && (r_sb[k].rd == w_rs2_ext)));
    assign w_slot_haz[k] = w_match &&
                           ((FWD != 0) ? (r_sb[k].is_load && (k < LOAD_LAT))
                                       : (k < PIPE_D - 1));
  end

  assign w_raw_stall = |w_slot_haz;

  // Non-writers are recorded as invalid: they can never be a RAW source.
  assign w_id_rec = '{vld:     id_vld && id_rd_wen,
                      rd:      REC_RD_W'(id_rd),
                      is_load: id_is_load};

  // Pipeline register controls, priority busy > taken branch > RAW stall.
  always_comb begin
    pc_hold    = 1'b0;
    if_id_en   = 1'b1;
    id_ex_en   = 1'b1;
    ex_mem_en  = 1'b1;
    if_id_clr  = 1'b0;
    id_ex_clr  = 1'b0;
    ex_mem_clr = 1'b0;
    if (ex_busy) begin
      pc_hold    = 1'b1;
      if_id_en   = 1'b0;
      id_ex_en   = 1'b0;
      ex_mem_clr = 1'b1;
    end else if (ex_take_br) begin
      if_id_clr  = 1'b1;
      id_ex_clr  = 1'b1;
    end else if (w_raw_stall) begin
      pc_hold    = 1'b1;
      if_id_en   = 1'b0;
      id_ex_clr  = 1'b1;
    end
  end

  // Scoreboard tracks the pipeline: EX holds while busy and drops a bubble
  // into MEM; otherwise everything shifts and ID (or a bubble) enters EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE_D; k++) r_sb[k] <= BUBBLE_REC;
    end else if (ex_busy) begin
      r_sb[1] <= BUBBLE_REC;
      for (int k = 2; k < PIPE_D; k++) r_sb[k] <= r_sb[k-1];
    end else begin
      r_sb[0] <= id_ex_clr ? BUBBLE_REC : w_id_rec;
      for (int k = 1; k < PIPE_D; k++) r_sb[k] <= r_sb[k-1];
    end
  end

  // A stall only counts when it actually took effect.
  assign w_stall_inc = ex_busy || (w_raw_stall && !ex_take_br);
  assign w_flush_inc = ex_take_br && !ex_busy;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall_inc),
    .clr (1'b0),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_flush_inc),
    .clr (1'b0),
    .cnt (flush_cnt)
  );

endmodule
